// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, legality check and
// the sequencer state encoding. The ALU and its bench use the same opcodes.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } seq_state_t;

    // Codes above MUL (101..111) have no ALU function behind them.
    function automatic logic is_legal_op(input logic [2:0] f);
        return (f <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with async active-high reset. Pointers wrap
// naturally because DEPTH is a power of two. Push is ignored when full and
// pop is ignored when empty, so the caller cannot corrupt the occupancy.
module alu_cmd_fifo #(
    parameter int DW    = 67,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    import alu_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Flags come straight from the registered count, no bypass.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        rdata   = mem[rd_ptr];
    end

    // Storage needs no reset; only entries below count are ever read as valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Command buffer and sequencer in front of the combinational ALU.
// Commands queue in a FIFO, are popped into registered ALU operands, held
// for the MUL window when needed, and the ALU result is captured into a
// valid/ready output register.
//
// state | meaning
// IDLE  | no command in the ALU; pop the FIFO head as soon as one exists
// EXEC  | operands driven to the ALU; count down cnt, then capture when the
//       | output slot is free (pop next command on the same edge if present)
module alu_issue_stage #(
    parameter int W          = 32,
    parameter int DEPTH      = 4,
    parameter int MUL_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic [2:0]             in_f,
    output logic [W-1:0]           alu_a,
    output logic [W-1:0]           alu_b,
    output logic [2:0]             alu_f,
    input  logic [W-1:0]           alu_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_y,
    output logic [2:0]             out_f,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] count
);
    import alu_pkg::*;

    localparam int DW    = 2 * W + 3;
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] load_cnt;

    logic             push;
    logic             pop;
    logic             capture;
    logic             slot_free;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    head;
    logic [W-1:0]     head_a;
    logic [W-1:0]     head_b;
    logic [2:0]       head_f;

    alu_cmd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_a, in_b, in_f}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake and head decode; in_ready is held low while in reset.
    always_comb begin
        in_ready  = !rst && !fifo_full;
        push      = in_valid && in_ready;
        slot_free = !out_valid || out_ready;
        head_a    = head[DW-1 -: W];
        head_b    = head[W+2 -: W];
        head_f    = head[2:0];
        load_cnt  = (head_f == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
    end

    // Next-state, MUL countdown, pop and capture decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cnt_d   = load_cnt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (slot_free) begin
                    capture = 1'b1;
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        cnt_d = load_cnt;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and MUL hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ALU operand registers load only on pop, so they stay stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_f <= OP_AND;
        end else if (pop) begin
            alu_a <= head_a;
            alu_b <= head_b;
            alu_f <= head_f;
        end
    end

    // Output register: a capture wins over a same-edge consumer accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_f     <= OP_AND;
            out_err   <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_y     <= is_legal_op(alu_f) ? alu_y : '0;
            out_f     <= alu_f;
            out_err   <= !is_legal_op(alu_f);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
